// File: rtl/cpu_pkg.sv
// Shared types and constants for the sequencer and its neighbours on the 8-bit datapath.
package cpu_pkg;

  localparam int PC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } seq_state_t;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;
  localparam logic [1:0] FMT_SYS = 2'b11;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load on start, step by one or jump to a branch target, wraps modulo 2^W.
module pc_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_addr,
  input  logic         i_step,
  input  logic         i_br_taken,
  input  logic [W-1:0] i_br_target,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;
  logic [W-1:0] w_pc_nxt;

  // Next-PC select: a start load has priority over a step; a step takes the branch target when taken.
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_load) begin
      w_pc_nxt = i_load_addr;
    end else if (i_step) begin
      w_pc_nxt = i_br_taken ? i_br_target : (r_pc + W'(1));
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and writeback control.
module seq_ctrl #(
  parameter int PC_W        = cpu_pkg::PC_W,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_address_i,
  input  logic [1:0]      format_i,
  input  logic [3:0]      opcode_i,
  input  logic [3:0]      alu_inst_i,
  input  logic            alu_branch_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            mem_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic            ir_le_o,
  output logic [3:0]      alu_inst_o,
  output logic            imm_sel_o,
  output logic            rf_we_o,
  output logic            wb_sel_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            busy_o,
  output logic            halted_o,
  output logic            err_o,
  output logic [2:0]      state_o
);

  import cpu_pkg::*;

  // Last MEM cycle index before the wait is declared lost (counter starts at 0 on entry).
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  seq_state_t r_state;
  logic [1:0] r_fmt;
  logic [7:0] r_tmo;
  logic [3:0] r_alu_inst;
  logic       r_ir_le;
  logic       r_imm_sel;
  logic       r_rf_we;
  logic       r_wb_sel;
  logic       r_mem_req;
  logic       r_mem_we;
  logic       r_busy;
  logic       r_halted;
  logic       r_err;

  logic       w_idle_like;
  logic       w_pc_load;
  logic       w_pc_step;
  logic       w_br_taken;

  // PC control: load on accepted start, advance after a branch, a completed store, or writeback.
  always_comb begin
    w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALT) || (r_state == ST_ERR);
    w_pc_load   = w_idle_like && start_i;
    w_br_taken  = (r_state == ST_EXEC) && (r_fmt == FMT_BR) && alu_branch_i;
    w_pc_step   = ((r_state == ST_EXEC) && (r_fmt == FMT_BR)) ||
                  ((r_state == ST_MEM) && mem_ack_i && r_mem_we) ||
                  (r_state == ST_WB);
  end

  pc_reg #(
    .W(PC_W)
  ) u_pc_reg (
    .clk         (clk),
    .i_rst_n     (rst_n_i),
    .i_load      (w_pc_load),
    .i_load_addr (start_address_i),
    .i_step      (w_pc_step),
    .i_br_taken  (w_br_taken),
    .i_br_target (branch_target_i),
    .o_pc        (pc_o)
  );

  // Sequencer FSM; every control output is registered and set on the edge entering its state.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_fmt      <= FMT_R;
      r_tmo      <= '0;
      r_alu_inst <= '0;
      r_ir_le    <= 1'b0;
      r_imm_sel  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ir_le <= 1'b0;
      r_rf_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALT, ST_ERR: begin
          if (start_i) begin
            r_state  <= ST_FETCH;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_state <= ST_DECODE;
          r_ir_le <= 1'b1;
        end
        ST_DECODE: begin
          r_alu_inst <= alu_inst_i;
          r_imm_sel  <= (format_i == FMT_I);
          r_fmt      <= format_i;
          if (format_i == FMT_SYS) begin
            if (opcode_i == OP_HALT) begin
              r_state  <= ST_HALT;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else if ((opcode_i == OP_LD) || (opcode_i == OP_ST)) begin
              r_state   <= ST_MEM;
              r_mem_req <= 1'b1;
              r_mem_we  <= opcode_i[0];
              r_tmo     <= '0;
            end else begin
              r_state <= ST_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_fmt == FMT_BR) begin
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_WB;
            r_rf_we <= 1'b1;
          end
        end
        ST_MEM: begin
          // An ack on the final allowed cycle still completes the access.
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_mem_we) begin
              r_state <= ST_FETCH;
            end else begin
              r_state  <= ST_WB;
              r_wb_sel <= 1'b1;
              r_rf_we  <= 1'b1;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_state   <= ST_ERR;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        ST_WB: begin
          r_state  <= ST_FETCH;
          r_wb_sel <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ir_le_o    = r_ir_le;
  assign alu_inst_o = r_alu_inst;
  assign imm_sel_o  = r_imm_sel;
  assign rf_we_o    = r_rf_we;
  assign wb_sel_o   = r_wb_sel;
  assign mem_req_o  = r_mem_req;
  assign mem_we_o   = r_mem_we;
  assign busy_o     = r_busy;
  assign halted_o   = r_halted;
  assign err_o      = r_err;
  assign state_o    = r_state;

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Multi-cycle sequencer for the 8-bit datapath: fetch, decode, execute and writeback.
- Owns the 16-bit PC and steps the instruction ROM → control → regfile → ALU path through one instruction at a time.
- Generates regfile write enables, operand/writeback selects and a load/store handshake to data memory.
- Replaces free-running fetch plus manual start pulsing with a single controller for start, branch, halt and error.

Parameters:
- PC_W, 16, program counter width
- MEM_TIMEOUT, 15, maximum cycles in MEM waiting for mem_ack_i before error (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n_i  in  1  synchronous active-low reset
- start_i  in  1  begin execution at start_address_i; honoured only in IDLE, HALT or ERR
- start_address_i  in  PC_W  initial PC
- format_i  in  2  decoded instruction format: 00 R, 01 I, 10 branch, 11 mem/sys
- opcode_i  in  4  instruction opcode
- alu_inst_i  in  4  ALU op from control decoder
- alu_branch_i  in  1  ALU branch-taken flag, valid in EXEC
- branch_target_i  in  PC_W  branch destination
- mem_ack_i  in  1  data memory completion, single-cycle pulse
- pc_o  out  PC_W  current PC to instruction ROM
- ir_le_o  out  1  instruction-field latch enable, high in DECODE
- alu_inst_o  out  4  registered ALU op, held from DECODE through WB
- imm_sel_o  out  1  ALU operand 2 = immediate (format 01)
- rf_we_o  out  1  regfile write enable, one cycle
- wb_sel_o  out  1  writeback source: 0 ALU, 1 memory
- mem_req_o  out  1  memory request, level, held until ack
- mem_we_o  out  1  1 = store, 0 = load; valid while mem_req_o
- busy_o  out  1  high in FETCH through WB
- halted_o  out  1  high in HALT
- err_o  out  1  high in ERR
- state_o  out  3  state encoding for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset (rst_n_i low at a clk edge) overrides everything, including mid-instruction:
  - state ← IDLE; pc_o ← 0; alu_inst_o ← 0.
  - All control outputs and the timeout counter ← 0.
- IDLE/HALT/ERR:
  - On start_i=1: pc ← start_address_i, next state FETCH; err_o and halted_o clear on that edge.
  - start_i is ignored in every other state.
- FETCH: one cycle; ROM is combinational on pc_o. → DECODE.
- DECODE:
  - ir_le_o=1; alu_inst_o ← alu_inst_i; imm_sel_o ← (format_i==01).
  - format 11, opcode 1111 → HALT; pc is not advanced.
  - format 11, opcode 0000 (load) or 0001 (store) → MEM; mem_req_o ← 1, mem_we_o ← opcode[0].
  - format 11 with any other opcode → ERR (illegal instruction).
  - Otherwise → EXEC.
- EXEC:
  - format 10: pc ← branch_target_i if alu_branch_i=1, else pc+1; → FETCH. No writeback.
  - format 00/01: → WB.
- MEM:
  - Hold mem_req_o and mem_we_o; count cycles.
  - On mem_ack_i=1: mem_req_o ← 0. Load → WB with wb_sel_o=1. Store → pc+1, FETCH.
  - Counter reaching MEM_TIMEOUT without ack → ERR, mem_req_o ← 0.
  - An ack arriving on the timeout cycle wins.
- WB: rf_we_o=1 for exactly this cycle; pc ← pc+1; → FETCH. wb_sel_o returns to 0 on exit.
- Cycle counts per instruction: ALU 4, branch 3, store 3+wait, load 4+wait.
- PC arithmetic is modulo 2^PC_W: 16'hFFFF+1 → 16'h0000, no flag.
- mem_ack_i outside MEM is ignored.
- Reset asserted in MEM drops mem_req_o on the same edge.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum seq_state_t
  - format constants FMT_R, FMT_I, FMT_BR, FMT_SYS
  - opcode constants OP_LD, OP_ST, OP_HALT
  - PC_W
- Natural sub-module pc_reg: load, increment and branch-select mux with reset; the FSM stays in seq_ctrl.

Test Plan:
- Reset then start_i=1, start_address_i=5, ROM R-type ADD at 5 → states 1,2,3,5; rf_we_o=1 only in WB; pc_o=6 at the next FETCH.
- Branch at pc=6 (format 10), alu_branch_i=1, branch_target_i=10 → pc_o=10 after EXEC, rf_we_o never asserted; with alu_branch_i=0 → pc_o=7.
- Load with mem_ack_i after 3 cycles → mem_req_o high 3 cycles, mem_we_o=0, then WB with wb_sel_o=1 and rf_we_o=1; store → no WB, pc+1.
- Load with mem_ack_i never asserted → err_o=1 after MEM_TIMEOUT cycles, mem_req_o=0; start_i restarts with err_o cleared.
- HALT opcode at 16'hFFFF → halted_o=1, pc_o stays FFFF; an ALU instruction at FFFF wraps pc_o to 0000.
- rst_n_i=0 during MEM with mem_req_o=1 → next cycle state_o=0, pc_o=0, all controls 0; start_i pulses mid-EXEC have no effect.
